fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage: the successor to the single-cycle PC register + PC mux.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC and issues one request at a
// time to a variable-latency instruction memory. Each fetched word is held in an
// output register and handed to decode under a valid/ready handshake.
// Redirects from execute replace the PC, and stale responses are discarded.
// Fetch stops for good after the HALT_OPC word has been accepted by decode.
//
// Handshakes:
//   imem side:  imem_req is a one-cycle strobe per request, and at most one
//               request is outstanding. imem_rvalid is accepted only in WAIT or
//               DROP and is ignored in every other state.
//   decode side: a word transfers on a cycle where if_valid & id_ready is high
//               and no redirect is present. if_instr and if_pc stay stable while
//               if_valid=1 and id_ready=0.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_cnt and stall_cnt
// performance counters.
// fsm_state exposes the internal FSM state for debug.
module fetch_unit #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 2,
  parameter int              OPC_MSB  = 15,
  parameter logic [3:0]      HALT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_inc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              hlt,
  output logic [ADDR_W-1:0] pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DROP  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              started;   // low until the first clock edge after reset
  logic              load_word; // capture the memory response into the output register
  logic              clr_valid; // the held word leaves the output register
  logic              handshake; // decode accepted the held word

  assign imem_req  = (state == S_FETCH) && started;
  assign imem_addr = pc;
  assign if_pc_inc = if_pc + STEP;
  assign fsm_state = state;

  // Next-state and next-PC decode; a redirect always wins over the other events
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_word = 1'b0;
    clr_valid = 1'b0;
    handshake = 1'b0;
    case (state)
      S_FETCH: begin
        if (started) begin
          if (redirect_valid) begin
            // The request is still issued this cycle, so its response must be dropped.
            pc_nxt    = redirect_pc;
            state_nxt = S_DROP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = imem_rvalid ? S_FETCH : S_DROP;
        end else if (imem_rvalid) begin
          load_word = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          clr_valid = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = S_FETCH;
        end else if (id_ready) begin
          clr_valid = 1'b1;
          handshake = 1'b1;
          pc_nxt    = pc + STEP;
          state_nxt = (if_instr[OPC_MSB -: 4] == HALT_OPC) ? S_HALT : S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_nxt = redirect_pc;
        if (imem_rvalid) state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // FSM state, PC and the halt flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      started <= 1'b0;
      hlt     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      started <= 1'b1;
      hlt     <= (state_nxt == S_HALT);
    end
  end

  // Output register holding the fetched word for decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      if (load_word) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end else if (clr_valid) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters. Both freeze in HALT because neither event can occur there.
  // A word that is redirected away in HOLD is not counted as a fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == S_HOLD) && !id_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. u_dut uses RESET_PC=0 and a
// latency-programmable memory model. u_wrap uses RESET_PC=16'hFFFE to exercise
// PC wrap and reset in the middle of a WAIT.
// Inputs are driven 1 ns after the rising edge. Outputs are checked on the
// falling edge, or 1 ns after the rising edge in the directed sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  int          n_vec  = 0;
  int          n_miss = 0;

  // u_dut signals
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata  = '0;
  logic        if_valid;
  logic        id_ready = 1'b1;
  logic [15:0] if_instr, if_pc, if_pc_inc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc    = '0;
  logic        hlt;
  logic [15:0] pc;
  logic [2:0]  dut_state;

  // u_wrap signals
  logic        w_rst = 1'b0;
  logic        w_imem_req;
  logic [15:0] w_imem_addr;
  logic        w_rvalid = 1'b0;
  logic [15:0] w_rdata  = '0;
  logic        w_if_valid;
  logic        w_id_ready = 1'b1;
  logic [15:0] w_if_instr, w_if_pc, w_if_pc_inc;
  logic        w_redirect_valid = 1'b0;
  logic [15:0] w_redirect_pc    = '0;
  logic        w_hlt;
  logic [15:0] w_pc;
  logic [2:0]  w_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

  // Scoreboards: expected request addresses and expected {pc, instr} handshakes
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  // Memory model state
  logic [15:0] mem [0:255];
  int          mem_lat = 1;
  logic        m_pend  = 1'b0;
  int          m_cnt   = 0;
  logic [15:0] m_addr  = '0;
  logic        w_pend  = 1'b0;

  fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .id_ready(id_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_inc(if_pc_inc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .hlt(hlt), .pc(pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .fsm_state(dut_state)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_valid(w_if_valid), .id_ready(w_id_ready),
    .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc_inc(w_if_pc_inc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .hlt(w_hlt), .pc(w_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(w_fetch_cnt), .stall_cnt(w_stall_cnt),
`endif
    .fsm_state(w_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_miss++;
    $display("FAIL %s got=timeout exp=event", tag);
  endtask

  task automatic wait_req(input logic [15:0] a, input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == a) found = 1;
    end
    if (!found) timeout(tag);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (if_valid) found = 1;
    end
    if (!found) timeout(tag);
  endtask

  // Memory model for u_dut: answers each request mem_lat cycles later
  always begin
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (!rst) begin
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[m_addr[8:1]];
          m_pend      = 1'b0;
        end
      end
      if (imem_req) begin
        m_pend = 1'b1;
        m_cnt  = mem_lat;
        m_addr = imem_addr;
      end
    end
  end

  // Memory model for u_wrap: fixed one-cycle latency, constant word
  always begin
    @(posedge clk);
    #1;
    if (!w_rst) begin
      w_pend   = 1'b0;
      w_rvalid = 1'b0;
    end else begin
      w_rvalid = w_pend;
      w_rdata  = 16'h2000;
      w_pend   = w_imem_req;
    end
  end

  // Scoreboard monitor on u_dut: request order, handshake contents, link value
  always @(negedge clk) begin
    if (rst) begin
      if (imem_req) begin
        if (exp_addr_q.size() > 0) check("req_addr", imem_addr, exp_addr_q.pop_front());
        else check("unexp_req", imem_req, 0);
      end
      if (if_valid) check("pc_inc", if_pc_inc, 16'(if_pc + 16'd2));
      if (if_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() > 0) check("handshake", {if_pc, if_instr}, exp_q.pop_front());
        else check("unexp_hs", if_valid, 0);
      end
    end
  end

  // Directed sequence
  initial begin
    int nreq;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(2 * i);
    mem[3] = 16'h1234;
    mem[4] = 16'hBEEF;
    mem[8] = 16'hF000;

    // Reset state
    repeat (3) cyc();
    check("rst_pc", pc, 16'h0000);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 16'h0000);
    check("rst_if_pc", if_pc, 16'h0000);
    check("rst_hlt", hlt, 0);
    check("rst_req", imem_req, 0);

    exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008,
                   16'h0040, 16'h0100, 16'h0010};
    exp_q      = '{{16'h0000, 16'h1000}, {16'h0002, 16'h1002}, {16'h0004, 16'h1004},
                   {16'h0006, 16'h1234}, {16'h0010, 16'hF000}};

    // Sequential fetch at L=1, then stall three cycles on the word at 0x0006
    rst = 1'b1;
    wait_req(16'h0006, "wait_req6");
    id_ready = 1'b0;
    wait_valid("wait_hold6");
    for (int i = 0; i < 3; i++) begin
      check("stall_instr", if_instr, 16'h1234);
      check("stall_pc", if_pc, 16'h0006);
      check("stall_req", imem_req, 0);
      cyc();
    end
    id_ready = 1'b1;
    mem_lat  = 3;

    // Redirect in WAIT; the late 0xBEEF response must be dropped
    wait_req(16'h0008, "wait_req8");
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 32'd3);
    check("fetch_cnt4", fetch_cnt, 32'd4);
`endif
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    cyc();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    check("drop_req", imem_req, 0);
    cyc();
    cyc();
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 16'h0040);
    check("redir_valid", if_valid, 0);

    // Redirect and id_ready together in HOLD: redirect wins
    wait_valid("wait_hold40");
    check("hold40_instr", if_instr, 16'h1040);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    cyc();
    redirect_valid = 1'b0;
    check("hold_redir_addr", imem_addr, 16'h0100);

    // Jump to the halt word at 0x0010 and let decode accept it
    wait_valid("wait_hold100");
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    cyc();
    redirect_valid = 1'b0;
    wait_valid("wait_hold10");
    check("halt_word", if_instr, 16'hF000);
    check("halt_not_yet", hlt, 0);
    cyc();
    check("hlt", hlt, 1);
    check("hlt_pc", pc, 16'h0012);
    check("hlt_valid", if_valid, 0);
    check("hlt_state", dut_state, 3'd4);
    for (int i = 0; i < 6; i++) begin
      redirect_valid = (i == 2);
      redirect_pc    = 16'h0200;
      cyc();
      check("hlt_no_req", imem_req, 0);
      check("hlt_pc_frozen", pc, 16'h0012);
    end
    redirect_valid = 1'b0;
    check("hlt_sticky", hlt, 1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt_frozen", fetch_cnt, 32'd5);
`endif
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("hs_q_empty", exp_q.size(), 0);

    // PC wrap from 0xFFFE and reset in the middle of WAIT
    w_rst = 1'b1;
    nreq  = 0;
    for (int i = 0; i < 20 && nreq < 2; i++) begin
      cyc();
      if (w_imem_req) begin
        nreq++;
        if (nreq == 1) check("wrap_addr0", w_imem_addr, 16'hFFFE);
        else check("wrap_addr1", w_imem_addr, 16'h0000);
      end
    end
    if (nreq < 2) timeout("wrap_req");
    cyc();
    check("wrap_pc", w_pc, 16'h0000);
    check("wrap_if_pc", w_if_pc, 16'hFFFE);
    check("wrap_pc_inc", w_if_pc_inc, 16'h0000);
    w_rst = 1'b0;
    #1;
    check("midrst_pc", w_pc, 16'hFFFE);
    check("midrst_valid", w_if_valid, 0);
    check("midrst_req", w_imem_req, 0);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
